jy_irq_event_gen: RTL and testbench
===================================

// Module: jy_irq_event_gen
// PURPOSE
// Event front-end for the J.Y. Company IRQ prescaler. Turns raw CPU/PPU bus activity into a clean one-clk
// event pulse, one source selected by irq_mode[1:0]. Sits directly upstream of the mapper's prescaler/counter
// and replaces its raw irq_source decode. Adds an M2-timed PPU A12 rising-edge filter so that sprite-fetch
// A12 chatter produces one event per scanline.
// PARAMETERS
// LOW_M2    3  consecutive M2 (ce) cycles with A12 sampled low needed before a rising edge is accepted
// HIGH_PPU  2  consecutive ppu_ce samples of A12 high needed to confirm an edge (glitch reject)
// CNT_W     4  width of the internal low-time counter; must hold LOW_M2
// PORTS
// clk         in   1  system clock (single clock domain)
// reset       in   1  synchronous, active-high reset
// ce          in   1  M2 CPU-cycle strobe, one clk wide
// ppu_ce      in   1  PPU-cycle strobe, one clk wide
// prg_write   in   1  CPU write qualifier, meaningful only when ce=1
// chr_read    in   1  PPU read qualifier, meaningful only when ppu_ce=1
// chr_a12     in   1  PPU address bit 12 (chr_ain_o[12]), sampled only on ppu_ce
// irq_mode    in   2  00 M2 cycle, 01 filtered A12 rise, 10 PPU read, 11 CPU write
// src_enable  in   1  gate; 0 suppresses event and holds the A12 filter in LOW_WAIT
// event       out  1  one-clk event pulse to the prescaler
// a12_state   out  2  filter state (debug/verification visibility)
// BEHAVIOUR
// - Reset: event=0, a12_state=LOW_WAIT(00), low counter=0, high counter=0, a12 sample reg=0.
// - All outputs are registered. event is asserted on the clk after the qualifying strobe (latency 1 clk)
//   and is high for exactly one clk.
// - Mode 00: event <= ce. Mode 10: event <= ppu_ce & chr_read. Mode 11: event <= ce & prg_write.
// - Mode 01 uses the A12 FSM. States: LOW_WAIT=00, ARMED=01, HIGH_CHK=10, HIGH=11.
//   LOW_WAIT: on ce, if the registered A12 sample is 0, increment lowcnt, saturating at LOW_M2.
//             Move to ARMED when lowcnt reaches LOW_M2.
//             On a ppu_ce with A12=1, clear lowcnt and stay in LOW_WAIT.
//   ARMED:    on ppu_ce with A12=1, go to HIGH_CHK with hicnt=1. If HIGH_PPU=1, go straight to HIGH and pulse event.
//   HIGH_CHK: on ppu_ce with A12=1, increment hicnt. When hicnt reaches HIGH_PPU, go to HIGH and pulse event.
//             On ppu_ce with A12=0, return to ARMED with no event (glitch rejected, low time kept).
//   HIGH:     on ppu_ce with A12=0, go to LOW_WAIT with lowcnt=0.
// - The A12 FSM runs in every mode, so switching to mode 01 takes effect with the existing filter history.
//   The event pulse itself is emitted only while irq_mode=01.
// - ce and ppu_ce in the same clk: the ppu_ce transition is evaluated first. A ce increments lowcnt only
//   when the FSM remains in LOW_WAIT and the new A12 sample is 0.
// - Counters saturate and never wrap. lowcnt is CNT_W bits and clamps at LOW_M2.
// - src_enable=0 forces event=0 and the FSM to LOW_WAIT with lowcnt=0, hicnt=0. The 0->1 transition
//   therefore needs a full LOW_M2 low period before the first A12 event.
// - A change of irq_mode takes effect on the next strobe. No event is synthesized from the mode change itself.
// - Reset asserted mid-sequence (any state) returns to LOW_WAIT on the next clk. No event is emitted in that clk.
// TESTING
// 1 reset, mode 00, 10 ce pulses -> 10 event pulses, each 1 clk, 1 clk after ce; none once reset asserts.
// 2 mode 01, A12 low for 3 ce, then 2 ppu_ce with A12=1 -> exactly one event, a12_state=11.
//   Further A12 highs -> no more events.
// 3 mode 01, A12 low for only 2 ce, then high -> no event, state stays 00.
//   Next low for 3 ce, then high x2 -> one event.
// 4 mode 01 in ARMED: 1 ppu_ce high, 1 ppu_ce low, 2 ppu_ce high -> glitch rejected,
//   then one event with no re-arm needed.
// 5 mode 10: 8 ppu_ce with chr_read=1 and 3 with chr_read=0 -> 8 events.
//   Mode 11: 4 ce with prg_write -> 4 events.
// 6 src_enable dropped in HIGH_CHK -> state 00, no event.
//   Raised again with A12 high immediately -> no event until 3 low ce plus 2 high ppu_ce.

Source files
------------

// File: rtl/jy_irq_event_gen.sv
// Event front-end for the J.Y. IRQ prescaler: selects one bus-activity source and emits a
// registered one-clk event pulse, with an M2-timed PPU A12 rising-edge filter for mode 01.
module jy_irq_event_gen #(
    parameter int unsigned LOW_M2   = 3,
    parameter int unsigned HIGH_PPU = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ce_i,
    input  logic       ppu_ce_i,
    input  logic       prg_write_i,
    input  logic       chr_read_i,
    input  logic       chr_a12_i,
    input  logic [1:0] irq_mode_i,
    input  logic       src_enable_i,
    output logic       event_o,
    output logic [1:0] a12_state_o
);

    localparam logic [1:0] LOW_WAIT = 2'b00;
    localparam logic [1:0] ARMED    = 2'b01;
    localparam logic [1:0] HIGH_CHK = 2'b10;
    localparam logic [1:0] HIGH     = 2'b11;

    localparam logic [CNT_W-1:0] LOW_MAX = CNT_W'(LOW_M2);
    localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(HIGH_PPU);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] lowcnt_q, lowcnt_d;
    logic [CNT_W-1:0] hicnt_q, hicnt_d;
    logic [CNT_W-1:0] hicnt_inc;
    logic             a12_q, a12_d;
    logic             event_q, event_d;
    logic             fire;

    assign hicnt_inc = (hicnt_q >= HI_MAX) ? hicnt_q : hicnt_q + 1'b1;

    // PPU strobe is resolved first; a same-clk ce then only counts low time if the
    // filter stayed in LOW_WAIT and the freshly sampled A12 is low.
    always_comb begin
        state_d  = state_q;
        lowcnt_d = lowcnt_q;
        hicnt_d  = hicnt_q;
        a12_d    = ppu_ce_i ? chr_a12_i : a12_q;
        fire     = 1'b0;

        if (ppu_ce_i) begin
            case (state_q)
                LOW_WAIT: begin
                    if (chr_a12_i) lowcnt_d = '0;
                end
                ARMED: begin
                    if (chr_a12_i) begin
                        hicnt_d = CNT_W'(1);
                        if (HIGH_PPU <= 1) begin
                            state_d = HIGH;
                            fire    = 1'b1;
                        end else begin
                            state_d = HIGH_CHK;
                        end
                    end
                end
                HIGH_CHK: begin
                    if (chr_a12_i) begin
                        hicnt_d = hicnt_inc;
                        if (hicnt_inc >= HI_MAX) begin
                            state_d = HIGH;
                            fire    = 1'b1;
                        end
                    end else begin
                        state_d = ARMED;
                        hicnt_d = '0;
                    end
                end
                default: begin
                    if (!chr_a12_i) begin
                        state_d  = LOW_WAIT;
                        lowcnt_d = '0;
                        hicnt_d  = '0;
                    end
                end
            endcase
        end

        if (ce_i && state_q == LOW_WAIT && state_d == LOW_WAIT && !a12_d) begin
            if (lowcnt_d < LOW_MAX) lowcnt_d = lowcnt_d + 1'b1;
            if (lowcnt_d >= LOW_MAX) state_d = ARMED;
        end
    end

    always_comb begin
        event_d = 1'b0;
        case (irq_mode_i)
            2'b00:   event_d = ce_i;
            2'b01:   event_d = fire;
            2'b10:   event_d = ppu_ce_i & chr_read_i;
            default: event_d = ce_i & prg_write_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= LOW_WAIT;
            lowcnt_q <= '0;
            hicnt_q  <= '0;
            a12_q    <= 1'b0;
            event_q  <= 1'b0;
        end else if (!src_enable_i) begin
            state_q  <= LOW_WAIT;
            lowcnt_q <= '0;
            hicnt_q  <= '0;
            a12_q    <= a12_d;
            event_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lowcnt_q <= lowcnt_d;
            hicnt_q  <= hicnt_d;
            a12_q    <= a12_d;
            event_q  <= event_d;
        end
    end

    assign event_o     = event_q;
    assign a12_state_o = state_q;

endmodule

// File: tb/tb_jy_irq_event_gen.sv
// Scoreboard bench for jy_irq_event_gen: the driver queues the expected event/state per cycle,
// a monitor pops and compares once the corresponding clock edge has been taken.
module tb_jy_irq_event_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0, ppu_ce = 1'b0, prg_write = 1'b0, chr_read = 1'b0, chr_a12 = 1'b0;
    logic [1:0] irq_mode = 2'b00;
    logic       src_enable = 1'b1;
    logic       event_o;
    logic [1:0] a12_state_o;

    logic       cur_rst = 1'b1;
    logic [1:0] cur_mode = 2'b00;
    logic       cur_en = 1'b1;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic  ev;
        int    st;
        string nm;
        int    due;
    } exp_t;
    exp_t q[$];

    jy_irq_event_gen #(.LOW_M2(3), .HIGH_PPU(2), .CNT_W(4)) dut (
        .clk_i(clk), .reset_i(reset), .ce_i(ce), .ppu_ce_i(ppu_ce),
        .prg_write_i(prg_write), .chr_read_i(chr_read), .chr_a12_i(chr_a12),
        .irq_mode_i(irq_mode), .src_enable_i(src_enable),
        .event_o(event_o), .a12_state_o(a12_state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one cycle of strobes; st < 0 means the filter state is not checked.
    task automatic step(input logic c, input logic p, input logic wr, input logic rd,
                        input logic a12, input logic ev, input int st, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = cur_rst; irq_mode = cur_mode; src_enable = cur_en;
        ce = c; ppu_ce = p; prg_write = wr; chr_read = rd; chr_a12 = a12;
        e.ev = ev; e.st = st; e.nm = nm; e.due = cyc + 1;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (event_o !== e.ev) begin
                    n_err++;
                    $display("FAIL %s event got %0b want %0b", e.nm, event_o, e.ev);
                end
                if (e.st >= 0) begin
                    n_cmp++;
                    if (a12_state_o !== 2'(e.st)) begin
                        n_err++;
                        $display("FAIL %s a12_state got %0d want %0d", e.nm, a12_state_o, e.st);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        step(0,0,0,0,0, 0, 0, "rst0");
        step(0,0,0,0,0, 0, 0, "rst1");

        // 1: mode 00 follows ce, reset suppresses
        cur_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1,0,0,0,0, 1, -1, "t1_ev");
            step(0,0,0,0,0, 0, -1, "t1_gap");
        end
        cur_rst = 1'b1;
        step(1,0,0,0,0, 0, 0, "t1_rst");
        step(1,0,0,0,0, 0, 0, "t1_rst2");
        cur_rst = 1'b0;

        // 2: clean A12 rise
        cur_mode = 2'b01;
        step(1,0,0,0,0, 0, 0, "t2_low1");
        step(1,0,0,0,0, 0, 0, "t2_low2");
        step(1,0,0,0,0, 0, 1, "t2_low3");
        step(0,1,0,0,1, 0, 2, "t2_hi1");
        step(0,1,0,0,1, 1, 3, "t2_hi2");
        step(0,1,0,0,1, 0, 3, "t2_hi3");
        step(1,0,0,0,0, 0, 3, "t2_ce_in_high");
        step(0,1,0,0,1, 0, 3, "t2_hi4");
        step(0,1,0,0,0, 0, 0, "t2_lo");

        // 3: short low time rejected, A12-high sample blocks counting
        step(1,0,0,0,0, 0, 0, "t3_low1");
        step(1,0,0,0,0, 0, 0, "t3_low2");
        step(0,1,0,0,1, 0, 0, "t3_early_hi");
        step(1,0,0,0,0, 0, 0, "t3_ce_a12hi");
        step(0,1,0,0,0, 0, 0, "t3_lo");
        step(1,0,0,0,0, 0, 0, "t3_low1b");
        step(1,0,0,0,0, 0, 0, "t3_low2b");
        step(1,0,0,0,0, 0, 1, "t3_low3b");
        step(0,1,0,0,1, 0, 2, "t3_hi1");
        step(0,1,0,0,1, 1, 3, "t3_hi2");
        step(0,1,0,0,0, 0, 0, "t3_lo_end");

        // 4: same-clk ce+ppu_ce ordering, then glitch rejection
        step(1,1,0,0,1, 0, 0, "t4_same_clk");
        step(0,1,0,0,0, 0, 0, "t4_lo");
        step(1,0,0,0,0, 0, 0, "t4_low1");
        step(1,0,0,0,0, 0, 0, "t4_low2");
        step(1,0,0,0,0, 0, 1, "t4_low3");
        step(0,1,0,0,1, 0, 2, "t4_hi_glitch");
        step(0,1,0,0,0, 0, 1, "t4_glitch_rej");
        step(0,1,0,0,1, 0, 2, "t4_hi1");
        step(0,1,0,0,1, 1, 3, "t4_hi2");
        step(0,1,0,0,0, 0, 0, "t4_lo_end");

        // 5: PPU read and CPU write modes; filter reaching HIGH outside mode 01 is silent
        cur_mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step(0,1,0,1,0, 1, -1, "t5_rd");
            step(0,0,0,0,0, 0, -1, "t5_rd_gap");
        end
        for (int i = 0; i < 3; i++) step(0,1,0,0,0, 0, 0, "t5_nord");
        cur_mode = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step(1,0,1,0,0, 1, (i < 2) ? 0 : 1, "t5_wr");
            step(0,0,0,0,0, 0, -1, "t5_wr_gap");
        end
        step(1,0,0,0,0, 0, 1, "t5_nowr");
        step(0,1,0,1,0, 0, 1, "t5_rd_m11");
        step(0,1,0,0,1, 0, 2, "t5_hi1");
        step(0,1,0,0,1, 0, 3, "t5_hi_nomode");
        step(0,1,0,0,0, 0, 0, "t5_lo");

        // 6: src_enable drop in HIGH_CHK, re-enable with A12 high
        cur_mode = 2'b01;
        step(1,0,0,0,0, 0, 0, "t6_low1");
        step(1,0,0,0,0, 0, 0, "t6_low2");
        step(1,0,0,0,0, 0, 1, "t6_low3");
        step(0,1,0,0,1, 0, 2, "t6_hi1");
        cur_en = 1'b0;
        step(0,1,0,0,1, 0, 0, "t6_drop");
        step(1,0,0,0,0, 0, 0, "t6_off");
        cur_en = 1'b1;
        step(0,1,0,0,1, 0, 0, "t6_hi_imm");
        step(0,1,0,0,1, 0, 0, "t6_hi_imm2");
        step(0,1,0,0,0, 0, 0, "t6_lo");
        step(1,0,0,0,0, 0, 0, "t6_rl1");
        step(1,0,0,0,0, 0, 0, "t6_rl2");
        step(1,0,0,0,0, 0, 1, "t6_rl3");
        step(0,1,0,0,1, 0, 2, "t6_rh1");
        step(0,1,0,0,1, 1, 3, "t6_rh2");
        step(0,1,0,0,0, 0, 0, "t6_lo_end");

        // reset mid-sequence and gating in mode 00
        step(1,0,0,0,0, 0, 0, "t7_low1");
        step(1,0,0,0,0, 0, 0, "t7_low2");
        step(1,0,0,0,0, 0, 1, "t7_low3");
        step(0,1,0,0,1, 0, 2, "t7_hi1");
        cur_rst = 1'b1;
        step(0,1,0,0,1, 0, 0, "t7_rst");
        cur_rst = 1'b0;
        step(0,1,0,0,1, 0, 0, "t7_after_rst");
        cur_mode = 2'b00;
        cur_en = 1'b0;
        step(1,0,0,0,0, 0, 0, "t8_gated");
        cur_en = 1'b1;
        step(1,0,0,0,0, 1, -1, "t8_ungated");
        step(0,0,0,0,0, 0, -1, "t8_idle");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
